// File: rtl/uart_lite_frame_bridge.sv
// AXI4-Lite master bridging an AXI UART Lite: polls STAT, buffers RX bytes in a
// circular buffer and writes them back to TX, either per byte or per frame.
module uart_lite_frame_bridge #(
  parameter int          DEPTH = 20,
  parameter int          AW    = 4,
  parameter int          MODE  = 1,
  parameter logic [7:0]  TERM  = 8'h0D
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [AW-1:0]              awaddr,
  output logic                       awvalid,
  input  logic                       awready,
  output logic [31:0]                wdata,
  output logic [3:0]                 wstrb,
  output logic                       wvalid,
  input  logic                       wready,
  input  logic [1:0]                 bresp,
  input  logic                       bvalid,
  output logic                       bready,
  output logic [AW-1:0]              araddr,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [31:0]                rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rvalid,
  output logic                       rready,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       frame_done,
  output logic                       busy,
  output logic                       err
);

  localparam int FW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [AW-1:0] A_RX   = AW'(0);
  localparam logic [AW-1:0] A_TX   = AW'(4);
  localparam logic [AW-1:0] A_STAT = AW'(8);
  localparam logic [AW-1:0] A_CTRL = AW'(12);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);

  typedef enum logic [3:0] {
    S_INIT, S_INIT_AW, S_INIT_B,
    S_POLL_AR, S_POLL_R,
    S_RX_AR, S_RX_R,
    S_TXS_AR, S_TXS_R,
    S_TX_AW, S_TX_B
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   awaddr_q, awaddr_d;
  logic            awvalid_q, awvalid_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic [AW-1:0]   araddr_q, araddr_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic            pending_q, pending_d;
  logic            frame_done_q, frame_done_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic [7:0]      mem [DEPTH];
  logic [7:0]      rd_byte_q;
  logic            mem_we;

  logic            ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic            aw_clear, w_clear;
  logic [FW-1:0]   fill_inc;
  logic            unused_rdata;

  assign ar_hs    = arvalid_q & arready;
  assign r_hs     = rvalid & rready_q;
  assign aw_hs    = awvalid_q & awready;
  assign w_hs     = wvalid_q & wready;
  assign b_hs     = bvalid & bready_q;
  assign aw_clear = ~awvalid_q | awready;
  assign w_clear  = ~wvalid_q | wready;
  assign fill_inc = fill_q + FW'(1);
  assign unused_rdata = ^rdata[31:8];

  // Registered read keeps the buffer mappable to block RAM; every read of
  // rd_byte_q happens at least two cycles after its pointer or data settles.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= rdata[7:0];
    end
    rd_byte_q <= mem[rd_ptr_q];
  end

  always_comb begin
    state_d      = state_q;
    awaddr_d     = awaddr_q;
    awvalid_d    = awvalid_q;
    wdata_d      = wdata_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    araddr_d     = araddr_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fill_d       = fill_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;
    err_d        = err_q;
    mem_we       = 1'b0;

    if ((r_hs && rresp != 2'b00) || (b_hs && bresp != 2'b00)) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_INIT: begin
        awaddr_d  = A_CTRL;
        wdata_d   = 8'h03;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        state_d   = S_INIT_AW;
      end

      // AW and W retire independently; B is awaited once both have gone.
      S_INIT_AW, S_TX_AW: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (aw_clear && w_clear) begin
          bready_d = 1'b1;
          state_d  = (state_q == S_INIT_AW) ? S_INIT_B : S_TX_B;
        end
      end

      S_INIT_B: begin
        if (b_hs) begin
          bready_d  = 1'b0;
          arvalid_d = 1'b1;
          araddr_d  = A_STAT;
          state_d   = S_POLL_AR;
        end
      end

      S_POLL_AR, S_RX_AR, S_TXS_AR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          case (state_q)
            S_POLL_AR: state_d = S_POLL_R;
            S_RX_AR:   state_d = S_RX_R;
            default:   state_d = S_TXS_R;
          endcase
        end
      end

      S_POLL_R: begin
        if (r_hs) begin
          rready_d  = 1'b0;
          arvalid_d = 1'b1;
          if (rdata[0] && !pending_q) begin
            araddr_d = A_RX;
            state_d  = S_RX_AR;
          end else if (MODE == 1 && pending_q) begin
            araddr_d = A_STAT;
            state_d  = S_TXS_AR;
          end else begin
            araddr_d = A_STAT;
            state_d  = S_POLL_AR;
          end
        end
      end

      S_RX_R: begin
        if (r_hs) begin
          rready_d  = 1'b0;
          mem_we    = 1'b1;
          wr_ptr_d  = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
          fill_d    = fill_inc;
          arvalid_d = 1'b1;
          araddr_d  = A_STAT;
          if (MODE == 0) begin
            state_d = S_TXS_AR;
          end else begin
            if (rdata[7:0] == TERM || fill_inc == FILL_FULL) begin
              pending_d = 1'b1;
            end
            state_d = S_POLL_AR;
          end
        end
      end

      S_TXS_R: begin
        if (r_hs) begin
          rready_d = 1'b0;
          if (rdata[3]) begin
            arvalid_d = 1'b1;
            araddr_d  = A_STAT;
            state_d   = S_TXS_AR;
          end else begin
            awaddr_d  = A_TX;
            wdata_d   = rd_byte_q;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_TX_AW;
          end
        end
      end

      S_TX_B: begin
        if (b_hs) begin
          bready_d  = 1'b0;
          rd_ptr_d  = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
          fill_d    = fill_q - FW'(1);
          arvalid_d = 1'b1;
          araddr_d  = A_STAT;
          if (MODE == 1 && fill_q != FW'(1)) begin
            state_d = S_TXS_AR;
          end else begin
            frame_done_d = 1'b1;
            pending_d    = 1'b0;
            state_d      = S_POLL_AR;
          end
        end
      end

      default: state_d = S_INIT;
    endcase

    busy_d = (state_d != S_POLL_AR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_INIT;
      awaddr_q     <= '0;
      awvalid_q    <= 1'b0;
      wdata_q      <= '0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      awaddr_q     <= awaddr_d;
      awvalid_q    <= awvalid_d;
      wdata_q      <= wdata_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      araddr_q     <= araddr_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign awaddr     = awaddr_q;
  assign awvalid    = awvalid_q;
  assign wdata      = {24'h0, wdata_q};
  assign wstrb      = 4'b0001;
  assign wvalid     = wvalid_q;
  assign bready     = bready_q;
  assign araddr     = araddr_q;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;
  assign fill       = fill_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule
